// File: rtl/psum_gbf_scheduler_pkg.sv
// Shared types and constants for the partial-sum global-buffer scheduler.
// Holds the scheduler state encoding and the double-buffer bank count.
package accel_pkg;

    localparam int NUM_BANKS = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TILE = 3'd1,
        ST_DRAIN     = 3'd2,
        ST_SWAP_WAIT = 3'd3,
        ST_FLUSH     = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

endpackage

// File: rtl/psum_gbf_scheduler_if.sv
// Handshake bundle between the psum scheduler and its PE array, accumulator and writeback peers.
// The master side is the environment; the slave side is the scheduler.
interface psum_gbf_scheduler_if #(
    parameter int GBF_ADDR_BITWIDTH = 5,
    parameter int CNT_BITWIDTH      = 8
);
    import accel_pkg::*;

    logic                         cfg_valid;
    logic [GBF_ADDR_BITWIDTH:0]   cfg_rel_num;
    logic [CNT_BITWIDTH-1:0]      cfg_irrel_num;
    logic                         pe_psum_finish;
    logic                         conv_finish;
    logic                         drain_done;
    logic                         rd_done;

    logic                         drain_start;
    logic                         wr_bank;
    logic                         wr_first;
    logic                         pe_hold;
    logic [NUM_BANKS-1:0]         bank_full;
    logic                         rd_valid;
    logic                         rd_bank;
    logic                         layer_done;
    logic [GBF_ADDR_BITWIDTH:0]   acc_rel_num;

    modport master (
        output cfg_valid, cfg_rel_num, cfg_irrel_num, pe_psum_finish,
               conv_finish, drain_done, rd_done,
        input  drain_start, wr_bank, wr_first, pe_hold, bank_full,
               rd_valid, rd_bank, layer_done, acc_rel_num
    );

    modport slave (
        input  cfg_valid, cfg_rel_num, cfg_irrel_num, pe_psum_finish,
               conv_finish, drain_done, rd_done,
        output drain_start, wr_bank, wr_first, pe_hold, bank_full,
               rd_valid, rd_bank, layer_done, acc_rel_num
    );

endinterface

// File: rtl/psum_gbf_scheduler_bank_tracker.sv
// Full flags for the two psum buffer banks and selection of the bank offered to writeback.
// A set and a readout-clear on different banks in the same cycle both take effect.
module psum_bank_tracker
    import accel_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 set_i,
    input  logic                 set_bank_i,
    input  logic                 rd_done_i,
    input  logic                 wr_bank_i,
    output logic [NUM_BANKS-1:0] bank_full_o,
    output logic                 rd_valid_o,
    output logic                 rd_bank_o
);

    logic [NUM_BANKS-1:0] bank_full_q, bank_full_d;
    logic                 rd_valid;
    logic                 rd_bank;

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_full_q <= '0;
        end else begin
            bank_full_q <= bank_full_d;
        end
    end

    // With both banks full, the one not being written is the older one.
    always_comb begin
        rd_valid = |bank_full_q;
        case (bank_full_q)
            2'b10:   rd_bank = 1'b1;
            2'b11:   rd_bank = ~wr_bank_i;
            default: rd_bank = 1'b0;
        endcase
    end

    always_comb begin
        bank_full_d = bank_full_q;
        if (rd_done_i && rd_valid) begin
            bank_full_d[rd_bank] = 1'b0;
        end
        if (set_i) begin
            bank_full_d[set_bank_i] = 1'b1;
        end
    end

    assign bank_full_o = bank_full_q;
    assign rd_valid_o  = rd_valid;
    assign rd_bank_o   = rd_bank;

endmodule

// File: rtl/psum_gbf_scheduler.sv
// Sequences PE tile drains into a double-buffered psum global buffer and hands full banks to writeback.
//
//   state        | meaning
//   -------------+-------------------------------------------------------------
//   ST_IDLE      | waiting for a layer configuration, PE array held
//   ST_WAIT_TILE | write bank available, accepting the next finished tile
//   ST_DRAIN     | accumulator draining one tile into wr_bank
//   ST_SWAP_WAIT | wr_bank filled, waiting for the other bank to be read out
//   ST_FLUSH     | layer issued, waiting for both banks to be read out
//   ST_DONE      | layer complete, held until reset
module psum_gbf_scheduler
    import accel_pkg::*;
#(
    parameter int GBF_ADDR_BITWIDTH = 5,
    parameter int CNT_BITWIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    psum_gbf_scheduler_if.slave  bus
);

    state_t                       state_q, state_d;
    logic [CNT_BITWIDTH-1:0]      pass_cnt_q, pass_cnt_d;
    logic [CNT_BITWIDTH-1:0]      irrel_q, irrel_d;
    logic [GBF_ADDR_BITWIDTH:0]   rel_q, rel_d;
    logic                         wr_bank_q, wr_bank_d;
    logic                         drain_start_q, drain_start_d;
    logic                         conv_pend_q, conv_pend_d;

    logic                         set_full;
    logic [NUM_BANKS-1:0]         bank_full;
    logic                         rd_valid;
    logic                         rd_bank;

    psum_bank_tracker u_bank_tracker (
        .clk         (clk),
        .reset       (reset),
        .set_i       (set_full),
        .set_bank_i  (wr_bank_q),
        .rd_done_i   (bus.rd_done),
        .wr_bank_i   (wr_bank_q),
        .bank_full_o (bank_full),
        .rd_valid_o  (rd_valid),
        .rd_bank_o   (rd_bank)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pass_cnt_q    <= '0;
            irrel_q       <= '0;
            rel_q         <= '0;
            wr_bank_q     <= 1'b0;
            drain_start_q <= 1'b0;
            conv_pend_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pass_cnt_q    <= pass_cnt_d;
            irrel_q       <= irrel_d;
            rel_q         <= rel_d;
            wr_bank_q     <= wr_bank_d;
            drain_start_q <= drain_start_d;
            conv_pend_q   <= conv_pend_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pass_cnt_d    = pass_cnt_q;
        irrel_d       = irrel_q;
        rel_d         = rel_q;
        wr_bank_d     = wr_bank_q;
        drain_start_d = 1'b0;
        conv_pend_d   = conv_pend_q;
        set_full      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_valid) begin
                    rel_d       = bus.cfg_rel_num;
                    irrel_d     = bus.cfg_irrel_num;
                    pass_cnt_d  = '0;
                    wr_bank_d   = 1'b0;
                    conv_pend_d = 1'b0;
                    state_d     = ST_WAIT_TILE;
                end
            end

            // A pending end-of-layer blocks new tiles; a partly filled bank is closed on the way out.
            ST_WAIT_TILE: begin
                if (bus.pe_psum_finish && !conv_pend_q) begin
                    drain_start_d = 1'b1;
                    conv_pend_d   = bus.conv_finish;
                    state_d       = ST_DRAIN;
                end else if (bus.conv_finish || conv_pend_q) begin
                    set_full   = (pass_cnt_q != '0);
                    pass_cnt_d = '0;
                    state_d    = ST_FLUSH;
                end
            end

            ST_DRAIN: begin
                if (bus.conv_finish) begin
                    conv_pend_d = 1'b1;
                end
                if (bus.drain_done) begin
                    if ((pass_cnt_q + CNT_BITWIDTH'(1)) == irrel_q) begin
                        set_full   = 1'b1;
                        pass_cnt_d = '0;
                        state_d    = ST_SWAP_WAIT;
                    end else begin
                        pass_cnt_d = pass_cnt_q + CNT_BITWIDTH'(1);
                        state_d    = ST_WAIT_TILE;
                    end
                end
            end

            ST_SWAP_WAIT: begin
                if (!bank_full[~wr_bank_q]) begin
                    wr_bank_d = ~wr_bank_q;
                    state_d   = ST_WAIT_TILE;
                end
            end

            ST_FLUSH: begin
                if (bank_full == '0) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_DONE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.drain_start = drain_start_q;
        bus.wr_bank     = wr_bank_q;
        bus.wr_first    = (state_q == ST_DRAIN) && (pass_cnt_q == '0);
        bus.pe_hold     = !((state_q == ST_WAIT_TILE) && !conv_pend_q);
        bus.bank_full   = bank_full;
        bus.rd_valid    = rd_valid;
        bus.rd_bank     = rd_bank;
        bus.layer_done  = (state_q == ST_DONE);
        bus.acc_rel_num = rel_q;
    end

endmodule

// File: doc/psum_gbf_scheduler.md
PSUM_GBF_SCHEDULER -- requirements
Module: psum_gbf_scheduler

Interface
REQ-001 Parameter GBF_ADDR_BITWIDTH, default 5, psum_gbf row address width (32 rows per bank).
REQ-002 Parameter CNT_BITWIDTH, default 8, width of pass counters.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cfg_valid  input  1  one-cycle pulse that loads the layer configuration; honoured only in IDLE.
REQ-006 cfg_rel_num  input  GBF_ADDR_BITWIDTH+1  rows written per drain, range 1..32.
REQ-007 cfg_irrel_num  input  CNT_BITWIDTH  drains accumulated into one bank before it is full, range 1..255.
REQ-008 pe_psum_finish  input  1  pulse: PE array holds a finished partial-sum tile.
REQ-009 conv_finish  input  1  pulse: last tile of the layer has been issued.
REQ-010 drain_done  input  1  pulse from accumulator: current drain complete.
REQ-011 rd_done  input  1  pulse from writeback: bank rd_bank has been read out.
REQ-012 drain_start  output  1  one-cycle pulse commanding the accumulator to drain one tile.
REQ-013 wr_bank  output  1  bank (0/1) currently being written.
REQ-014 wr_first  output  1  high during a drain that overwrites rather than accumulates (first pass into a bank).
REQ-015 pe_hold  output  1  stalls the PE array; high whenever a tile cannot be accepted.
REQ-016 bank_full  output  2  per-bank full flag.
REQ-017 rd_valid  output  1  a full bank is awaiting readout; rd_bank identifies it.
REQ-018 rd_bank  output  1  bank offered to writeback.
REQ-019 layer_done  output  1  level, high in DONE.

Function
REQ-020 States: IDLE, WAIT_TILE, DRAIN, SWAP_WAIT, FLUSH, DONE.
REQ-021 IDLE: cfg_valid latches cfg_rel_num/cfg_irrel_num, clears counters, wr_bank<=0 -> WAIT_TILE next cycle; pe_hold=1 in IDLE.
REQ-022 WAIT_TILE: pe_psum_finish -> drain_start asserted the following cycle for exactly one cycle, state -> DRAIN; wr_first=1 when pass_cnt==0.
REQ-023 DRAIN: pe_hold=1; on drain_done pass_cnt increments; if pass_cnt+1==cfg_irrel_num, bank_full[wr_bank]<=1 and pass_cnt<=0, then -> SWAP_WAIT; else -> WAIT_TILE.
REQ-024 SWAP_WAIT: if bank_full[~wr_bank]==0, wr_bank toggles and -> WAIT_TILE in the same cycle; otherwise pe_hold=1 and remain until rd_done frees that bank.
REQ-025 conv_finish in WAIT_TILE with pass_cnt!=0 -> FLUSH: mark current bank full, -> DONE once both banks empty; with pass_cnt==0 -> DONE directly once both banks empty.
REQ-026 conv_finish in DRAIN is recorded and acted upon after drain_done.
REQ-027 rd_valid=|bank_full; rd_bank = oldest full bank (bank not equal to wr_bank when both full); rd_done clears bank_full[rd_bank] next cycle.
REQ-028 rd_done with rd_valid=0 is ignored; pe_psum_finish outside WAIT_TILE is ignored (upstream honours pe_hold).
REQ-029 Simultaneous rd_done and bank_full set on the other bank: both take effect same cycle.
REQ-030 DONE: layer_done=1, pe_hold=1; cfg_valid is ignored; only reset leaves DONE.
REQ-031 Write address rows 0..cfg_rel_num-1 are owned by the accumulator; scheduler only forwards cfg_rel_num, no address wrap handling here.

Reset
REQ-032 reset overrides all inputs, including mid-drain: state<=IDLE, drain_start=0, wr_bank=0, wr_first=0, pe_hold=1, bank_full=2'b00, rd_valid=0, rd_bank=0, layer_done=0, counters and config cleared.

Structure
REQ-033 State encoding and the bank-count constant (2) reside in a shared package accel_pkg.
REQ-034 One sub-module, psum_bank_tracker, holds bank_full flags and rd_bank ordering; FSM and counters in the top.

Verification
REQ-035 cfg rel=4 irrel=2; two tiles with drain_done 6 cycles after each drain_start -> bank_full=01, wr_bank=1, rd_valid=1, rd_bank=0; wr_first=1 on first drain only.
REQ-036 irrel=1, four tiles, no rd_done -> after tiles 1,2 bank_full=11, pe_hold stays 1 in SWAP_WAIT; rd_done -> bank 0 freed, wr_bank=0, tile 3 drains.
REQ-037 irrel=3, two tiles then conv_finish -> FLUSH marks bank 0 full; rd_done -> layer_done=1.
REQ-038 conv_finish asserted mid-DRAIN -> no second drain_start; DONE reached after drain_done and all rd_done.
REQ-039 reset asserted during DRAIN -> next cycle all outputs at REQ-032 values; new cfg_valid restarts normally.
REQ-040 rd_done and bank fill in the same cycle -> bank_full transitions 01->10 with rd_bank=1.
